// File: rtl/udp_mux_pkg.sv
// Shared types and default sizing for the UDP channel multiplexer.
// The FSM state enum lives here so the bench and any future siblings agree on it.
package udp_mux_pkg;

  localparam int DEFAULT_CH_NUM     = 4;
  localparam int DEFAULT_PORT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN
  } mux_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or above ptr, with wrap.
// Produces both a one-hot grant and the binary index of the winner.
module rr_arbiter #(
  parameter int CH_NUM = 4
) (
  input  logic [CH_NUM-1:0]         req,
  input  logic [$clog2(CH_NUM)-1:0] ptr,
  output logic [CH_NUM-1:0]         gnt,
  output logic [$clog2(CH_NUM)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(CH_NUM);

  int c;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    c       = 0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % CH_NUM;
      if (req[c]) begin
        gnt      = '0;
        gnt[c]   = 1'b1;
        gnt_idx  = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/axis_udp_chan_mux.sv
// Packet-granular N-channel AXI-Stream mux with per-channel UDP port tagging,
// payload-limit truncation and frame/truncation statistics.
module axis_udp_chan_mux
  import udp_mux_pkg::*;
#(
  parameter int CH_NUM        = DEFAULT_CH_NUM,
  parameter int DATA_WIDTH    = 8,
  parameter int PORT_WIDTH    = DEFAULT_PORT_WIDTH,
  parameter int PAYLOAD_WIDTH = 11,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [CH_NUM-1:0]            s_tvalid_i,
  input  logic [CH_NUM-1:0]            s_tlast_i,
  output logic [CH_NUM-1:0]            s_tready_o,
  input  logic [CH_NUM-1:0]            ch_en_i,
  input  logic [CH_NUM*PORT_WIDTH-1:0] ch_port_i,
  input  logic [PAYLOAD_WIDTH-1:0]     payload_bytes_i,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic                         m_tvalid_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic [PORT_WIDTH-1:0]        m_port_o,
  output logic [$clog2(CH_NUM)-1:0]    m_chan_o,
  output logic [CNT_WIDTH-1:0]         frame_cnt_o,
  output logic [CNT_WIDTH-1:0]         trunc_cnt_o
);

  localparam int               IDX_W    = $clog2(CH_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

  mux_state_e               state, state_nxt;
  logic [IDX_W-1:0]         grant, rr_ptr, arb_idx;
  logic [CH_NUM-1:0]        arb_gnt;
  logic [PAYLOAD_WIDTH-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0]    ch_data [CH_NUM];
  logic [PORT_WIDTH-1:0]    ch_port [CH_NUM];
  logic                     sel_valid, sel_last, limit_hit, hs, pass_last;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slice
    assign ch_data[k] = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign ch_port[k] = ch_port_i[k*PORT_WIDTH +: PORT_WIDTH];
  end

  rr_arbiter #(.CH_NUM(CH_NUM)) u_arb (
    .req     (s_tvalid_i & ch_en_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign sel_valid = s_tvalid_i[grant];
  assign sel_last  = s_tlast_i[grant];
  assign m_tdata_o = ch_data[grant];
  assign m_chan_o  = grant;
  assign limit_hit = (payload_bytes_i != '0) &&
                     (beat_cnt == payload_bytes_i - PAYLOAD_WIDTH'(1));
  assign hs        = sel_valid & m_tready_i;
  assign pass_last = (state == PASS) && hs && (sel_last | limit_hit);

  // Handshake steering: only the granted channel ever sees ready.
  always_comb begin
    state_nxt  = state;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    s_tready_o = '0;
    case (state)
      IDLE: begin
        if (|arb_gnt) state_nxt = PASS;
      end
      PASS: begin
        m_tvalid_o        = sel_valid;
        m_tlast_o         = sel_last | limit_hit;
        s_tready_o[grant] = m_tready_i;
        if (pass_last) state_nxt = sel_last ? IDLE : DRAIN;
      end
      DRAIN: begin
        s_tready_o[grant] = 1'b1;
        if (sel_valid && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      m_port_o    <= '0;
      beat_cnt    <= '0;
      frame_cnt_o <= '0;
      trunc_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |arb_gnt) begin
        grant    <= arb_idx;
        m_port_o <= ch_port[arb_idx];
        beat_cnt <= '0;
      end
      // Saturate so an unlimited frame never wraps into a false limit hit.
      if (state == PASS && hs && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      if (pass_last) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
        rr_ptr      <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
        if (!sel_last) trunc_cnt_o <= trunc_cnt_o + 1'b1;
      end
    end
  end

endmodule
